// File: rtl/display_scan.sv
// -----------------------------------------------------------------------------
// display_scan
//   Time-multiplexed 4-digit common-anode seven-segment driver. It captures
//   the BCD tens/units digits and the sign flag from the converter on a load
//   strobe, then scans them onto the display one digit per slot. Leading
//   zeros are blanked, and the minus sign sits next to the most significant
//   shown digit. Non-BCD nibbles show as 'E'. Each slot starts with GUARD
//   blank cycles to prevent ghosting.
//
// Parameters
//   REFRESH_DIV  clock cycles per digit slot (2 .. 2**20)
//   GUARD        blanked cycles at the start of each slot (0 .. REFRESH_DIV-1)
//
// Ports
//   clk    system clock
//   rst    synchronous active-high reset
//   load   capture strobe for tens/unit/neg
//   tens   BCD tens digit
//   unit   BCD units digit
//   neg    result-is-negative flag
//   an     digit enables, active-low (an[0]=units .. an[3]=leftmost)
//   seg    segments {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] tens,
  input  logic [3:0] unit,
  input  logic       neg,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int               CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  // Active-low segment pattern for one nibble; anything above 9 shows 'E'.
  function automatic logic [6:0] nib_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  // Capture registers
  logic [3:0]       t_q, t_d;
  logic [3:0]       u_q, u_d;
  logic             n_q, n_d;
  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  // Registered outputs
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;

  logic       tens_nz;
  logic       is_neg;
  logic [6:0] digit_seg [4];

  // Digit contents from the captured value. A non-BCD tens nibble counts as
  // nonzero, so it is shown and pushes the sign out to digit 2.
  always_comb begin
    // NOTE: every signal driven here gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    tens_nz      = (t_q != 4'd0);
    // A negative zero is shown without a sign.
    is_neg       = n_q && (tens_nz || (u_q != 4'd0));
    digit_seg[0] = nib_seg(u_q);
    digit_seg[1] = SEG_BLANK;
    digit_seg[2] = SEG_BLANK;
    digit_seg[3] = SEG_BLANK;
    if (tens_nz) begin
      digit_seg[1] = nib_seg(t_q);
      if (is_neg) digit_seg[2] = SEG_MINUS;
    end else if (is_neg) begin
      digit_seg[1] = SEG_MINUS;
    end
  end

  always_comb begin
    t_d = t_q;
    u_d = u_q;
    n_d = n_q;
    if (load) begin
      t_d = tens;
      u_d = unit;
      n_d = neg;
    end

    if (cnt_q == LAST_C) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
    end

    // Outputs are computed from pre-edge state and land one cycle later.
    if (cnt_q < GUARD_C) begin
      an_d  = 4'b1111;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = digit_seg[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_q   <= 4'd0;
      u_q   <= 4'd0;
      n_q   <= 1'b0;
      cnt_q <= '0;
      idx_q <= 2'd0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register, independent of order.
      t_q   <= t_d;
      u_q   <= u_d;
      n_q   <= n_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
